// File: rtl/demux_pkg.sv
// Shared definitions for the 1:4 stream demultiplexer.
//   N_CH       number of output channels
//   SEL_W      width of the channel select
//   ch_sel_t   channel select type
//   sel_onehot decodes a channel select into a one-hot channel mask
package demux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] ch_sel_t;

  // Channel select to one-hot mask; bit k is set when sel == k.
  function automatic logic [N_CH-1:0] sel_onehot(input ch_sel_t sel);
    logic [N_CH-1:0] oh;
    oh      = {N_CH{1'b0}};
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_ch_slot.sv
// One-entry valid/ready output buffer for a single demux channel.
// Optional feature macro: DEMUX_CNT_EN adds a delivered-word counter.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load_i   in   write data_i into the slot this cycle
//   data_i   in   word to load
//   ready_i  in   consumer takes the held word (ignored while empty)
//   valid_o  out  slot holds a word (registered)
//   data_o   out  held word; keeps its last value after a pop (registered)
//   cnt_o    out  delivered-word count, wraps (DEMUX_CNT_EN only)
module demux_ch_slot
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [W-1:0]     data_i,
  input  logic             ready_i,
  output logic             valid_o,
`ifdef DEMUX_CNT_EN
  output logic [CNT_W-1:0] cnt_o,
`endif
  output logic [W-1:0]     data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         pop_s;

  // Next-state: a load wins over a pop so a same-cycle pop+load keeps valid high.
  always_comb begin
    pop_s = valid_q & ready_i;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_s) begin
      valid_d = 1'b0;
      data_d  = data_q;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count pops; wraps naturally at 2^CNT_W.
  always_comb begin
    if (pop_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Delivered-word counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1:4 stream demultiplexer. One input word is routed by in_sel to
// one of four one-entry output buffers; disabled channels drop their words.
// Optional feature macro: DEMUX_CNT_EN adds per-channel delivered counters on cnt_bus.
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   in_valid    in   input word present
//   in_ready    out  input may be accepted this cycle (combinational)
//   in_data     in   input word (W bits)
//   in_sel      in   destination channel 0..3
//   ch_en       in   per-channel enable; 0 drops words for that channel
//   out_valid   out  bit k: channel k holds a word
//   out_ready   in   bit k: channel k consumer takes the word
//   out_data    out  channel k word at [k*W +: W]
//   drop_pulse  out  one-cycle pulse after an accepted word was dropped
//   cnt_bus     out  channel k delivered count at [k*CNT_W +: CNT_W] (DEMUX_CNT_EN only)
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  input  ch_sel_t               in_sel,
  input  logic [N_CH-1:0]       ch_en,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [N_CH*W-1:0]     out_data,
`ifdef DEMUX_CNT_EN
  output logic [N_CH*CNT_W-1:0] cnt_bus,
`endif
  output logic                  drop_pulse
);

  logic [N_CH-1:0] sel_oh_s;
  logic [N_CH-1:0] load_s;
  logic            en_sel_s;
  logic            accept_s;
  logic            drop_d;
  logic            drop_q;

  // Input handshake: a disabled channel always accepts (the word is dropped),
  // an enabled one accepts when its slot is empty or being popped this cycle.
  always_comb begin
    sel_oh_s = sel_onehot(in_sel);
    en_sel_s = ch_en[in_sel];
    in_ready = ~en_sel_s | ~out_valid[in_sel] | out_ready[in_sel];
    accept_s = in_valid & in_ready;
    if (accept_s & en_sel_s) begin
      load_s = sel_oh_s;
    end else begin
      load_s = {N_CH{1'b0}};
    end
    drop_d = accept_s & ~en_sel_s;
  end

  // Drop indication register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_pulse = drop_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_ch_slot #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load_s[k]),
      .data_i  (in_data),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
`ifdef DEMUX_CNT_EN
      .cnt_o   (cnt_bus[k*CNT_W +: CNT_W]),
`endif
      .data_o  (out_data[k*W +: W])
    );
  end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream: directed scenarios followed by
// random traffic, all compared against a per-channel behavioural model.
module tb_demux_1_4_stream;

  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int NC    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic [1:0]        in_sel;
  logic [NC-1:0]     ch_en;
  logic [NC-1:0]     out_valid;
  logic [NC-1:0]     out_ready;
  logic [NC*W-1:0]   out_data;
  logic              drop_pulse;
`ifdef DEMUX_CNT_EN
  logic [NC*CNT_W-1:0] cnt_bus;
`endif

  demux_1_4_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .ch_en      (ch_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef DEMUX_CNT_EN
    .cnt_bus    (cnt_bus),
`endif
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: what each channel currently holds.
  bit         m_valid [NC];
  logic [7:0] m_data  [NC];
  bit         m_drop;
  int         m_cnt   [NC];
  bit         last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = 8'h00;
      m_cnt[k]   = 0;
    end
    m_drop = 1'b0;
  endtask

  // One clock: compare at the falling edge, then advance the model over the rising edge.
  task automatic cycle();
    bit         exp_rdy;
    bit         acc;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] en;
    logic [3:0] rdy;
    @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("valid%0d", k), out_valid[k], m_valid[k]);
      chk($sformatf("data%0d", k), out_data[k*W +: W], m_data[k]);
`ifdef DEMUX_CNT_EN
      chk($sformatf("cnt%0d", k), cnt_bus[k*CNT_W +: CNT_W], m_cnt[k]);
`endif
    end
    chk("drop", drop_pulse, m_drop);
    s   = in_sel;
    d   = in_data;
    en  = ch_en;
    rdy = out_ready;
    // A word for a disabled channel is always taken; otherwise the slot must be free or draining.
    exp_rdy = (en[s] == 1'b0) || !m_valid[s] || (rdy[s] == 1'b1);
    chk("in_ready", in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    @(posedge clk);
    m_drop = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (m_valid[k] && rdy[k]) begin
        m_valid[k] = 1'b0;
        m_cnt[k]   = (m_cnt[k] + 1) % (1 << CNT_W);
      end
    end
    if (acc) begin
      if (en[s]) begin
        m_valid[s] = 1'b1;
        m_data[s]  = d;
      end else begin
        m_drop = 1'b1;
      end
    end
    last_acc = acc;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    ch_en     = 4'hF;
    out_ready = 4'h0;
    last_acc  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. reset, idle
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_data", out_data, 32'h0);
    chk("rst_drop", drop_pulse, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    cycle();

    // 2. back-to-back words to all four channels
    out_ready = 4'hF;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hA0 + 8'(i);
      in_sel  = 2'(i);
      cycle();
      chk("b2b_valid", out_valid[i], 1'b1);
      chk("b2b_data", out_data[i*W +: W], 8'hA0 + 8'(i));
    end
    in_valid = 1'b0;
    cycle();

    // 3. stalled channel 2, then pop and reload in the same cycle
    out_ready = 4'b1011;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    in_sel    = 2'd2;
    cycle();
    in_data = 8'h22;
    #1;
    chk("stall_ready", in_ready, 1'b0);
    cycle();
    chk("stall_hold", out_data[2*W +: W], 8'h11);
    out_ready = 4'hF;
    #1;
    chk("unstall_ready", in_ready, 1'b1);
    cycle();
    chk("reload_valid", out_valid[2], 1'b1);
    chk("reload_data", out_data[2*W +: W], 8'h22);
    in_valid = 1'b0;
    cycle();

    // 4. disabled channel drops
    ch_en    = 4'b1101;
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_sel   = 2'd1;
    cycle();
    in_valid = 1'b0;
    chk("drop_pulse", drop_pulse, 1'b1);
    chk("drop_novalid", out_valid[1], 1'b0);
    cycle();
    chk("drop_once", drop_pulse, 1'b0);

    // 5. reset while a word is stalled on channel 3
    ch_en     = 4'hF;
    out_ready = 4'b0111;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    in_sel    = 2'd3;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("pre_rst_valid", out_valid[3], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 4'b0000);
    chk("mid_rst_data", out_data, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 4'h0;
    cycle();

`ifdef DEMUX_CNT_EN
    // 6. counter wrap on channel 0
    out_ready = 4'hF;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("cnt_wrap0", cnt_bus[0 +: CNT_W], 4'd1);
    chk("cnt_other", cnt_bus[CNT_W +: 3*CNT_W], 12'h000);
`endif

    // 7. random traffic; a stalled word is held stable until accepted
    last_acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        in_sel   = 2'($urandom);
      end
      ch_en     = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
      out_ready = 4'($urandom);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 4'hF;
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
